disp_window_driver: RTL
=======================

# disp_window_driver

Parametrised display scan-out driver that generates video timing and fetches a SRC_H×SRC_V image from a show-ahead read FIFO into a run-time-positioned window of a larger visible raster. Pixels outside the window are filled with a programmable background colour. Input word format is selectable (RGB888 or RGB565). FIFO underflow is detected, concealed and counted per frame. It sits between the frame-buffer read FIFO and the HDMI/TMDS encoder.

## Interface
- SRC_H, 800, source image width in pixels
- SRC_V, 480, source image height in lines
- H_LENGTH / H_SYNC_LEN / H_BP_LEN / H_VISIBLE / H_SYNC_POL, 2200/44/148/1920/1, horizontal timing (total, sync, back porch, active, 1 = active-high)
- V_LENGTH / V_SYNC_LEN / V_BP_LEN / V_VISIBLE / V_SYNC_POL, 1125/5/36/1080/1, vertical timing
- pixel_clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- ext_sync  in  1  frame restart strobe
- win_x / win_y  in  14  requested window origin in visible coordinates
- bg_color  in  24  RGB888 fill colour
- fmt_565  in  1  0: pixel = dout[31:8]; 1: RGB565 in dout[15:0], expanded by MSB replication
- rdfifo_rden  out  1  FIFO read enable (show-ahead FIFO)
- rdfifo_dout  in  32  FIFO data, valid in the same cycle as rden
- rdfifo_empty  in  1  FIFO empty flag
- rd_load  out  1  one-cycle pulse at frame start; upstream reload
- video_vsync / video_hsync / video_den / video_line_start  out  1  timing outputs
- video_pixel  out  24  RGB888, R in [23:16]
- underflow_cnt  out  16  underflow count of the previous frame, saturating

## Operation
- Counters: h_cnt runs 0..H_LENGTH-1. v_cnt increments when h_cnt wraps and runs 0..V_LENGTH-1.
- Sync is active while h_cnt < H_SYNC_LEN (v_cnt < V_SYNC_LEN) and is driven at the polarity set by *_SYNC_POL.
- Active region: h_cnt in [H_SYNC_LEN+H_BP_LEN, +H_VISIBLE) and v_cnt in the corresponding vertical range. pixel_x / pixel_y are the offsets from the start of that region.
- Frame start is h_cnt==0 && v_cnt==0. At frame start:
  - latch win_x, win_y, bg_color and fmt_565;
  - clamp each origin: wx = min(win_x, H_VISIBLE-SRC_H), wy likewise;
  - pulse rd_load.
- in_win = den && pixel_x in [wx, wx+SRC_H) && pixel_y in [wy, wy+SRC_V).
- rdfifo_rden = in_win && !rdfifo_empty. This signal is combinational from the counter state and is forced 0 during reset.
- Pixel select:
  - in_win with data: formatted dout;
  - in_win with empty FIFO (underflow): latched bg_color, and the frame counter increments, saturating at 0xFFFF;
  - otherwise: latched bg_color;
  - den=0: 24'h0.
- At frame start, underflow_cnt takes the frame counter value and the frame counter clears. If an underflow coincides with frame start, it counts toward the new frame.
- ext_sync=1 forces h_cnt=v_cnt=0 on the next cycle, which is a frame start. It overrides the normal increment.
- Reset values:
  - counters 0; hsync/vsync at the inactive level;
  - den, line_start, rd_load 0; pixel 0; underflow_cnt 0;
  - latched window 0,0; bg 0; fmt 0.
- Reset mid-frame restarts from frame start once reset is released.

## Timing
- All video_* outputs are registered, with one cycle of latency from counter state. rdfifo_rden is sampled in stage 0, so dout is captured in the same edge that registers video_pixel.
- rd_load is registered and asserts one cycle after the frame-start counter state. It is therefore coincident with the first vsync-active output cycle.
- video_line_start is a one-cycle pulse coincident with the first video_den cycle of each active line.
- Exactly SRC_H×SRC_V reads occur per frame when the FIFO never underflows.

## Structure
- Shared package disp_pkg: pixel-format constants, RGB565→888 expansion function, timing-parameter defaults (1080p, 720p).
- Sub-module disp_timing_gen: counters, ext_sync, sync/den/pixel_x/pixel_y/frame_start.
- Top level: window latch/clamp, FIFO read, format, underflow accounting, output registers.

## Test plan
Small timing for all scenarios: H 20/2/3/12, V 10/1/2/5, SRC 4×2.
- Window (3,1), FIFO always full → 8 rden pulses per frame, at pixel_x 3..6 on pixel_y 1..2; all other den pixels = bg_color.
- win_x=20 → clamped to 8; reads land at pixel_x 8..11.
- fmt_565=1, dout[15:0]=16'hF800 → video_pixel 24'hFF0000; fmt_565=0, dout=32'h12345600 → 24'h123456.
- FIFO empty for 3 in-window cycles → bg shown on those pixels, rden=0 there, underflow_cnt=3 after the next frame start.
- ext_sync pulse mid-line → next cycle is a frame start; rd_load pulses one cycle later; window inputs changed mid-frame take effect only then.
- reset asserted mid-frame for 2 cycles → every output is at its reset value the cycle after reset is sampled, and the timing restarts at frame start.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display window driver: coordinate and colour
// types, input pixel formats, the RGB565 expansion helper and default
// video timings for 1080p60 and 720p60.
package disp_pkg;

    // Raster coordinates and counters share one width so that they compare
    // directly against each other without casts.
    localparam int COORD_W = 14;
    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so that origin + size cannot wrap.
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef logic [23:0] rgb888_t;

    localparam int UF_CNT_W = 16;
    typedef logic [UF_CNT_W-1:0] uf_cnt_t;

    // Layout of a FIFO word.
    typedef enum logic {
        PIX_FMT_888 = 1'b0,   // pixel in word[31:8]
        PIX_FMT_565 = 1'b1    // pixel in word[15:0], RGB565
    } pix_fmt_e;

    // 1920x1080 @ 60 Hz, 148.5 MHz pixel clock.
    localparam int T1080_H_LENGTH   = 2200;
    localparam int T1080_H_SYNC_LEN = 44;
    localparam int T1080_H_BP_LEN   = 148;
    localparam int T1080_H_VISIBLE  = 1920;
    localparam int T1080_H_SYNC_POL = 1;
    localparam int T1080_V_LENGTH   = 1125;
    localparam int T1080_V_SYNC_LEN = 5;
    localparam int T1080_V_BP_LEN   = 36;
    localparam int T1080_V_VISIBLE  = 1080;
    localparam int T1080_V_SYNC_POL = 1;

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock.
    localparam int T720_H_LENGTH    = 1650;
    localparam int T720_H_SYNC_LEN  = 40;
    localparam int T720_H_BP_LEN    = 220;
    localparam int T720_H_VISIBLE   = 1280;
    localparam int T720_H_SYNC_POL  = 1;
    localparam int T720_V_LENGTH    = 750;
    localparam int T720_V_SYNC_LEN  = 5;
    localparam int T720_V_BP_LEN    = 20;
    localparam int T720_V_VISIBLE   = 720;
    localparam int T720_V_SYNC_POL  = 1;

    // Expand RGB565 to RGB888 by replicating each channel's MSBs into the
    // new LSBs, so full scale maps to 8'hFF and zero stays zero.
    function automatic rgb888_t expand_565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // Extract the RGB888 pixel from a FIFO word in the given format.
    function automatic rgb888_t format_word(input pix_fmt_e fmt,
                                            input logic [31:0] word);
        return (fmt == PIX_FMT_565) ? expand_565(word[15:0]) : word[31:8];
    endfunction

    // Keep a requested window origin inside the visible area.
    function automatic coord_t clamp_origin(input coord_t req, input coord_t lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/disp_timing_gen.sv
// Video timing generator: horizontal/vertical counters with an external
// frame restart, decoded into sync, data-enable and active-area pixel
// coordinates. All outputs are combinational from the counter state; the
// caller registers whatever it drives off-chip.
module disp_timing_gen
    import disp_pkg::*;
#(
    parameter int H_LENGTH   = T1080_H_LENGTH,
    parameter int H_SYNC_LEN = T1080_H_SYNC_LEN,
    parameter int H_BP_LEN   = T1080_H_BP_LEN,
    parameter int H_VISIBLE  = T1080_H_VISIBLE,
    parameter int V_LENGTH   = T1080_V_LENGTH,
    parameter int V_SYNC_LEN = T1080_V_SYNC_LEN,
    parameter int V_BP_LEN   = T1080_V_BP_LEN,
    parameter int V_VISIBLE  = T1080_V_VISIBLE
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               ext_sync,
    output logic               hsync_act,
    output logic               vsync_act,
    output logic               den,
    output logic               line_first,
    output logic               frame_start,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y
);

    localparam coord_t H_LAST      = coord_t'(H_LENGTH - 1);
    localparam coord_t V_LAST      = coord_t'(V_LENGTH - 1);
    localparam coord_t H_SYNC_END  = coord_t'(H_SYNC_LEN);
    localparam coord_t V_SYNC_END  = coord_t'(V_SYNC_LEN);
    localparam coord_t H_ACT_START = coord_t'(H_SYNC_LEN + H_BP_LEN);
    localparam coord_t H_ACT_END   = coord_t'(H_SYNC_LEN + H_BP_LEN + H_VISIBLE);
    localparam coord_t V_ACT_START = coord_t'(V_SYNC_LEN + V_BP_LEN);
    localparam coord_t V_ACT_END   = coord_t'(V_SYNC_LEN + V_BP_LEN + V_VISIBLE);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_active;
    logic   v_active;

    // Raster position: h_cnt wraps every line and steps v_cnt; reset and
    // ext_sync both send the raster back to the frame-start position.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ext_sync) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
        end else begin
            h_cnt <= h_cnt + coord_t'(1);
        end
    end

    // Sync pulses sit at the start of each line/frame, followed by the back
    // porch and then the visible region; the front porch is the remainder.
    assign hsync_act   = (h_cnt < H_SYNC_END);
    assign vsync_act   = (v_cnt < V_SYNC_END);
    assign h_active    = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    assign v_active    = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    assign den         = h_active && v_active;
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign line_first  = den && (h_cnt == H_ACT_START);

    // Offsets into the visible region; only meaningful while den is high.
    assign pixel_x = h_cnt - H_ACT_START;
    assign pixel_y = v_cnt - V_ACT_START;

endmodule

// File: rtl/disp_window_driver.sv
// Display scan-out driver. Places a SRC_H x SRC_V image, streamed from a
// show-ahead read FIFO, at a per-frame window origin inside the visible
// raster and fills the rest with a background colour. FIFO underflows inside
// the window are concealed with the background colour and counted per frame.
module disp_window_driver
    import disp_pkg::*;
#(
    parameter int SRC_H      = 800,
    parameter int SRC_V      = 480,
    parameter int H_LENGTH   = T1080_H_LENGTH,
    parameter int H_SYNC_LEN = T1080_H_SYNC_LEN,
    parameter int H_BP_LEN   = T1080_H_BP_LEN,
    parameter int H_VISIBLE  = T1080_H_VISIBLE,
    parameter int H_SYNC_POL = T1080_H_SYNC_POL,
    parameter int V_LENGTH   = T1080_V_LENGTH,
    parameter int V_SYNC_LEN = T1080_V_SYNC_LEN,
    parameter int V_BP_LEN   = T1080_V_BP_LEN,
    parameter int V_VISIBLE  = T1080_V_VISIBLE,
    parameter int V_SYNC_POL = T1080_V_SYNC_POL
) (
    input  logic                pixel_clock,
    input  logic                reset,
    input  logic                ext_sync,
    input  logic [COORD_W-1:0]  win_x,
    input  logic [COORD_W-1:0]  win_y,
    input  logic [23:0]         bg_color,
    input  logic                fmt_565,
    output logic                rdfifo_rden,
    input  logic [31:0]         rdfifo_dout,
    input  logic                rdfifo_empty,
    output logic                rd_load,
    output logic                video_vsync,
    output logic                video_hsync,
    output logic                video_den,
    output logic                video_line_start,
    output logic [23:0]         video_pixel,
    output logic [UF_CNT_W-1:0] underflow_cnt
);

    // Largest origins that still keep the whole image on screen.
    localparam coord_t     WX_MAX    = coord_t'(H_VISIBLE - SRC_H);
    localparam coord_t     WY_MAX    = coord_t'(V_VISIBLE - SRC_V);
    localparam coord_ext_t SRC_H_EXT = coord_ext_t'(SRC_H);
    localparam coord_ext_t SRC_V_EXT = coord_ext_t'(SRC_V);
    localparam logic       H_POL     = (H_SYNC_POL != 0);
    localparam logic       V_POL     = (V_SYNC_POL != 0);
    localparam uf_cnt_t    UF_MAX    = '1;

    // Stage 0: raster state from the timing generator.
    logic   hsync_act;
    logic   vsync_act;
    logic   den;
    logic   line_first;
    logic   frame_start;
    coord_t pixel_x;
    coord_t pixel_y;

    // Window parameters, frozen for the duration of a frame.
    coord_t   wx_lat;
    coord_t   wy_lat;
    rgb888_t  bg_lat;
    pix_fmt_e fmt_lat;

    // Window hit and FIFO status for the current raster position.
    logic    x_in;
    logic    y_in;
    logic    in_win;
    logic    fifo_hit;
    logic    underflow;
    rgb888_t fmt_pixel;
    rgb888_t pixel_next;

    // Running underflow count for the frame in progress.
    uf_cnt_t uf_frame;

    disp_timing_gen #(
        .H_LENGTH   (H_LENGTH),
        .H_SYNC_LEN (H_SYNC_LEN),
        .H_BP_LEN   (H_BP_LEN),
        .H_VISIBLE  (H_VISIBLE),
        .V_LENGTH   (V_LENGTH),
        .V_SYNC_LEN (V_SYNC_LEN),
        .V_BP_LEN   (V_BP_LEN),
        .V_VISIBLE  (V_VISIBLE)
    ) u_timing (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .ext_sync    (ext_sync),
        .hsync_act   (hsync_act),
        .vsync_act   (vsync_act),
        .den         (den),
        .line_first  (line_first),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y)
    );

    // Window control: sample and clamp the requested window once per frame so
    // that mid-frame changes never tear the image.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            wx_lat  <= '0;
            wy_lat  <= '0;
            bg_lat  <= '0;
            fmt_lat <= PIX_FMT_888;
        end else if (frame_start) begin
            wx_lat  <= clamp_origin(win_x, WX_MAX);
            wy_lat  <= clamp_origin(win_y, WY_MAX);
            bg_lat  <= bg_color;
            fmt_lat <= pix_fmt_e'(fmt_565);
        end
    end

    // Window hit test; comparisons are widened so origin + size cannot wrap.
    assign x_in   = (pixel_x >= wx_lat) &&
                    (coord_ext_t'(pixel_x) < coord_ext_t'(wx_lat) + SRC_H_EXT);
    assign y_in   = (pixel_y >= wy_lat) &&
                    (coord_ext_t'(pixel_y) < coord_ext_t'(wy_lat) + SRC_V_EXT);
    assign in_win = den && x_in && y_in;

    // Show-ahead FIFO: data is already on rdfifo_dout when rden is asserted,
    // so the read and the capture into video_pixel happen on the same edge.
    assign fifo_hit    = in_win && !rdfifo_empty;
    assign underflow   = in_win && rdfifo_empty;
    assign rdfifo_rden = fifo_hit && !reset;
    assign fmt_pixel   = format_word(fmt_lat, rdfifo_dout);

    // Pixel select: image data, background (outside the window or on
    // underflow), or black during blanking.
    always_comb begin
        // NOTE: default assignment first so every path drives pixel_next and
        // no latch is inferred.
        pixel_next = '0;
        if (den) begin
            if (fifo_hit) begin
                pixel_next = fmt_pixel;
            end else begin
                pixel_next = bg_lat;
            end
        end
    end

    // Underflow accounting: publish the finished frame's count at frame start
    // and restart counting, including an underflow landing on that cycle.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            uf_frame      <= '0;
            underflow_cnt <= '0;
        end else if (frame_start) begin
            underflow_cnt <= uf_frame;
            uf_frame      <= {{(UF_CNT_W-1){1'b0}}, underflow};
        end else if (underflow && (uf_frame != UF_MAX)) begin
            uf_frame      <= uf_frame + uf_cnt_t'(1);
        end
    end

    // Output registers: one cycle of latency from the raster state, syncs at
    // their configured polarity, rd_load aligned with the first vsync cycle.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            video_hsync      <= ~H_POL;
            video_vsync      <= ~V_POL;
            video_den        <= 1'b0;
            video_line_start <= 1'b0;
            video_pixel      <= '0;
            rd_load          <= 1'b0;
        end else begin
            video_hsync      <= H_POL ? hsync_act : ~hsync_act;
            video_vsync      <= V_POL ? vsync_act : ~vsync_act;
            video_den        <= den;
            video_line_start <= line_first;
            video_pixel      <= pixel_next;
            rd_load          <= frame_start;
        end
    end

endmodule
